burst_bridge: RTL and testbench

Sits directly below the CPU cache and serves its line-fill and writeback bursts. Each burst command (base address, read/write, length) from the cache side becomes a sequence of single-word requests to a one-outstanding word memory port (SRAM/DDR wrapper). The block paces the cache word by word through `lowmem_ready`. It also latches a command that arrives before memory init completes or while a burst is still running.

---
 rtl/burst_bridge_pkg.sv | 39 +++
 rtl/burst_cmd_slot.sv | 43 ++++
 rtl/burst_bridge.sv | 166 ++++++++++++++++
 tb/tb_burst_bridge.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_bridge_pkg.sv
// Shared types for the cache-to-memory burst bridge: FSM states, the
// captured command record and the burst length normalisation rule.
package burst_bridge_pkg;

    localparam int unsigned DEF_ADDR_STEP = 4;
    localparam int unsigned DEF_MAX_BURST = 32;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WR_ISSUE,
        ST_WR_WAIT
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [7:0]  len;
    } cmd_t;

    // Words actually moved: single word when bursting is off or length is 0,
    // otherwise the requested length clamped to the largest supported burst.
    function automatic logic [7:0] eff_len(input logic       en,
                                           input logic [7:0] len,
                                           input int unsigned max_burst);
        logic [7:0] n;
        if (!en || len == 8'd0) begin
            n = 8'd1;
        end else if ({24'd0, len} > max_burst) begin
            n = 8'(max_burst);
        end else begin
            n = len;
        end
        return n;
    endfunction

endpackage

// File: rtl/burst_cmd_slot.sv
// One-deep pending command register. A push into a full slot is dropped and
// raises a sticky overflow flag, unless the slot is popped in the same cycle,
// in which case the new command replaces the departing one.
module burst_cmd_slot
    import burst_bridge_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_push_cmd,
    input  logic i_pop,
    output logic o_valid,
    output cmd_t o_cmd,
    output logic o_overflow
);

    logic r_valid;
    cmd_t r_cmd;
    logic r_overflow;

    // Slot contents, valid bit and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_overflow <= 1'b0;
        end else if (i_push) begin
            if (!r_valid || i_pop) begin
                r_valid <= 1'b1;
                r_cmd   <= i_push_cmd;
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_cmd      = r_cmd;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/burst_bridge.sv
// Burst bridge between the CPU cache and a one-outstanding word memory port.
// Each burst command is split into single-word requests; the cache is paced
// one word at a time through lowmem_ready.
module burst_bridge
    import burst_bridge_pkg::*;
#(
    parameter int unsigned MAX_BURST = DEF_MAX_BURST,
    parameter int unsigned ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        burst_en,
    input  logic [7:0]  burst_length,
    input  logic [31:0] lowmem_a,
    input  logic [31:0] lowmem_d,
    input  logic        lowmem_we,
    input  logic        lowmem_rd,
    output logic [31:0] lowmem_spo,
    output logic        lowmem_ready,
    output logic        busy,
    output logic        overrun,
    input  logic        mem_init_done,
    output logic [31:0] mem_a,
    output logic [31:0] mem_d,
    output logic        mem_we,
    output logic        mem_rd,
    input  logic [31:0] mem_spo,
    input  logic        mem_ready
);

    localparam int unsigned KW    = $clog2(MAX_BURST + 1);
    localparam logic [KW-1:0] K_ONE = KW'(1);
    localparam logic [31:0]   STEP  = 32'(ADDR_STEP);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_push;
    logic          w_pop;
    logic          w_slot_valid;
    cmd_t          w_push_cmd;
    cmd_t          w_slot_cmd;
    logic [31:0]   r_addr;
    logic [31:0]   r_mem_d;
    logic [31:0]   r_rd_data;
    logic [31:0]   r_spo;
    logic [KW-1:0] r_k;
    logic [KW-1:0] w_k_next;
    logic [7:0]    r_len;
    logic          r_rd_pulse;
    logic          w_last;
    logic          w_wait_done;
    logic          w_wr_pulse;

    // Command capture: write wins when both pulses coincide.
    assign w_push = lowmem_we | lowmem_rd;

    // Normalised command record presented to the pending slot.
    always_comb begin
        w_push_cmd       = '0;
        w_push_cmd.addr  = lowmem_a;
        w_push_cmd.write = lowmem_we;
        w_push_cmd.len   = eff_len(burst_en, burst_length, MAX_BURST);
    end

    burst_cmd_slot u_slot (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_cmd (w_push_cmd),
        .i_pop      (w_pop),
        .o_valid    (w_slot_valid),
        .o_cmd      (w_slot_cmd),
        .o_overflow (overrun)
    );

    assign w_k_next    = r_k + K_ONE;
    assign w_last      = (8'(w_k_next) == r_len);
    assign w_wait_done = mem_ready & ((r_state == ST_RD_WAIT) | (r_state == ST_WR_WAIT));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, slot pop and per-state request strobes.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        mem_rd       = 1'b0;
        mem_we       = 1'b0;
        w_wr_pulse   = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (mem_init_done) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_slot_valid) begin
                    w_pop        = 1'b1;
                    w_state_next = w_slot_cmd.write ? ST_WR_ISSUE : ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                mem_rd       = 1'b1;
                w_state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_ready) w_state_next = w_last ? ST_IDLE : ST_RD_ISSUE;
            end
            ST_WR_ISSUE: begin
                mem_we       = 1'b1;
                w_wr_pulse   = 1'b1;
                w_state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (mem_ready) w_state_next = w_last ? ST_IDLE : ST_WR_ISSUE;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    // Word address/counter, write data capture and two-stage read return.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr     <= '0;
            r_k        <= '0;
            r_len      <= '0;
            r_mem_d    <= '0;
            r_rd_data  <= '0;
            r_rd_pulse <= 1'b0;
            r_spo      <= '0;
        end else begin
            r_rd_pulse <= 1'b0;
            if (w_pop) begin
                r_addr <= w_slot_cmd.addr;
                r_k    <= '0;
                r_len  <= w_slot_cmd.len;
            end else if (w_wait_done) begin
                r_addr <= r_addr + STEP;
                r_k    <= w_k_next;
            end
            if (w_wait_done && r_state == ST_RD_WAIT) begin
                r_rd_data  <= mem_spo;
                r_rd_pulse <= 1'b1;
            end
            if (r_rd_pulse) begin
                r_spo <= r_rd_data;
            end
            if (r_state == ST_WR_ISSUE) begin
                r_mem_d <= lowmem_d;
            end
        end
    end

    // The write request cycle forwards the cache word directly so the memory
    // sees it alongside mem_we; the register keeps it stable afterwards.
    assign mem_d        = (r_state == ST_WR_ISSUE) ? lowmem_d : r_mem_d;
    assign mem_a        = r_addr;
    assign lowmem_spo   = r_spo;
    assign lowmem_ready = r_rd_pulse | w_wr_pulse;
    assign busy         = (r_state != ST_IDLE) | w_slot_valid;

endmodule

// File: tb/tb_burst_bridge.sv
// Self-checking bench for burst_bridge: a memory/cache responder records every
// word request and handshake, and each scenario compares those records with
// the expected burst computed from the command.
module tb_burst_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        burst_en;
    logic [7:0]  burst_length;
    logic [31:0] lowmem_a;
    logic [31:0] lowmem_d;
    logic        lowmem_we;
    logic        lowmem_rd;
    logic [31:0] lowmem_spo;
    logic        lowmem_ready;
    logic        busy;
    logic        overrun;
    logic        mem_init_done;
    logic [31:0] mem_a;
    logic [31:0] mem_d;
    logic        mem_we;
    logic        mem_rd;
    logic [31:0] mem_spo;
    logic        mem_ready;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mem_lat = 1;

    logic [31:0] q_req_a[$];
    logic        q_req_we[$];
    logic [31:0] q_req_d[$];
    int          q_rdy_cyc[$];
    logic [31:0] q_spo[$];
    logic [31:0] q_rsp[$];
    logic [31:0] wdata[$];
    int          wr_idx = 0;

    always #5 clk = ~clk;

    burst_bridge #(.MAX_BURST(32), .ADDR_STEP(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .burst_en      (burst_en),
        .burst_length  (burst_length),
        .lowmem_a      (lowmem_a),
        .lowmem_d      (lowmem_d),
        .lowmem_we     (lowmem_we),
        .lowmem_rd     (lowmem_rd),
        .lowmem_spo    (lowmem_spo),
        .lowmem_ready  (lowmem_ready),
        .busy          (busy),
        .overrun       (overrun),
        .mem_init_done (mem_init_done),
        .mem_a         (mem_a),
        .mem_d         (mem_d),
        .mem_we        (mem_we),
        .mem_rd        (mem_rd),
        .mem_spo       (mem_spo),
        .mem_ready     (mem_ready)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory with fixed latency plus a cache that advances its write word one
    // cycle after each write handshake; everything observed is logged.
    initial begin
        int  pend = 0;
        bit  pend_rd = 0;
        bit  spo_due = 0;
        bit  wr_adv = 0;
        mem_ready = 1'b0;
        mem_spo   = '0;
        lowmem_d  = '0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_spo   = $urandom;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_ready = 1'b1;
                    if (pend_rd) q_rsp.push_back(mem_spo);
                end
            end
            if (mem_rd || mem_we) begin
                q_req_a.push_back(mem_a);
                q_req_we.push_back(mem_we);
                q_req_d.push_back(mem_d);
                pend    = mem_lat;
                pend_rd = mem_rd;
            end
            if (spo_due) q_spo.push_back(lowmem_spo);
            spo_due = 0;
            if (wr_adv) begin
                wr_idx++;
                lowmem_d = (wr_idx < wdata.size()) ? wdata[wr_idx] : $urandom;
                wr_adv = 0;
            end
            if (lowmem_ready) begin
                q_rdy_cyc.push_back(cyc);
                if (mem_we) wr_adv = 1;
                else        spo_due = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

    function automatic int exp_words(input bit en, input logic [7:0] len);
        if (!en || len == 8'd0) return 1;
        if (len > 8'd32) return 32;
        return int'(len);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        q_req_a.delete(); q_req_we.delete(); q_req_d.delete();
        q_rdy_cyc.delete(); q_spo.delete(); q_rsp.delete();
    endtask

    task automatic load_wdata(input int n);
        wdata.delete();
        for (int i = 0; i < n; i++) wdata.push_back($urandom);
        wr_idx   = 0;
        lowmem_d = wdata[0];
    endtask

    task automatic send(input bit we, input bit rd, input logic [31:0] a,
                        input bit en, input logic [7:0] len);
        lowmem_we = we; lowmem_rd = rd; lowmem_a = a;
        burst_en = en;  burst_length = len;
        tick(1);
        lowmem_we = 1'b0; lowmem_rd = 1'b0; lowmem_a = $urandom;
        burst_en = 1'($urandom_range(0, 1)); burst_length = 8'($urandom);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, want 0", nm, busy, n);
        end
        tick(3);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_init_done = 1'b0; lowmem_we = 1'b0; lowmem_rd = 1'b0;
        lowmem_a = '0; burst_en = 1'b0; burst_length = '0;
        tick(3);
        vectors++;
        if ({lowmem_ready, mem_we, mem_rd, overrun, busy} !== 5'b00001) begin
            miscompares++;
            $display("FAIL reset_flags: rdy/we/rd/ovr/busy=%b want 00001",
                     {lowmem_ready, mem_we, mem_rd, overrun, busy});
        end
        vectors++;
        if ({lowmem_spo, mem_a, mem_d} !== 96'd0) begin
            miscompares++;
            $display("FAIL reset_data: spo=%h a=%h d=%h want zeros", lowmem_spo, mem_a, mem_d);
        end
        rst = 1'b1;
        tick(4);
        vectors++;
        if (busy !== 1'b1 || q_req_a.size() != 0) begin
            miscompares++;
            $display("FAIL init_wait: busy=%b reqs=%0d want busy=1 reqs=0", busy, q_req_a.size());
        end
    endtask

    task automatic test_init_hold();
        clear_q();
        mem_lat = $urandom_range(1, 3);
        send(1'b0, 1'b1, 32'h1000, 1'b1, 8'd32);
        tick(5);
        vectors++;
        if (q_req_a.size() != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL init_pending: reqs=%0d busy=%b want 0/1", q_req_a.size(), busy);
        end
        mem_init_done = 1'b1;
        wait_idle("init_burst", 400);
        vectors++;
        if (q_req_a.size() != 32 || q_rdy_cyc.size() != 32) begin
            miscompares++;
            $display("FAIL init_count: reqs=%0d rdy=%0d want 32/32", q_req_a.size(), q_rdy_cyc.size());
        end
        for (int i = 0; i < q_req_a.size() && i < 32; i++) begin
            vectors++;
            if ({q_req_we[i], q_req_a[i]} !== {1'b0, 32'h1000 + 32'(4 * i)}) begin
                miscompares++;
                $display("FAIL init_addr[%0d]: we=%b a=%h want 0 %h", i, q_req_we[i], q_req_a[i],
                         32'h1000 + 32'(4 * i));
            end
        end
        vectors++;
        if (q_spo.size() != 32 || q_rsp.size() != 32) begin
            miscompares++;
            $display("FAIL init_rdata_count: spo=%0d rsp=%0d want 32/32", q_spo.size(), q_rsp.size());
        end
        for (int i = 0; i < q_spo.size() && i < q_rsp.size(); i++) begin
            vectors++;
            if (q_spo[i] !== q_rsp[i]) begin
                miscompares++;
                $display("FAIL init_rdata[%0d]: spo=%h want %h", i, q_spo[i], q_rsp[i]);
            end
        end
    endtask

    task automatic test_write_burst();
        int c;
        clear_q();
        mem_lat = 1;
        wdata.delete();
        for (int i = 0; i < 4; i++) wdata.push_back(32'hA0 + 32'(i));
        wr_idx = 0; lowmem_d = wdata[0];
        c = cyc;
        send(1'b1, 1'b0, 32'h20, 1'b1, 8'd4);
        wait_idle("wr_burst", 100);
        vectors++;
        if (q_req_a.size() != 4 || q_rdy_cyc.size() != 4) begin
            miscompares++;
            $display("FAIL wr_count: reqs=%0d rdy=%0d want 4/4", q_req_a.size(), q_rdy_cyc.size());
        end
        for (int i = 0; i < q_req_a.size() && i < 4; i++) begin
            vectors++;
            if ({q_req_we[i], q_req_a[i], q_req_d[i]} !== {1'b1, 32'h20 + 32'(4 * i), 32'hA0 + 32'(i)}) begin
                miscompares++;
                $display("FAIL wr_word[%0d]: we=%b a=%h d=%h want 1 %h %h", i, q_req_we[i],
                         q_req_a[i], q_req_d[i], 32'h20 + 32'(4 * i), 32'hA0 + 32'(i));
            end
        end
        if (q_rdy_cyc.size() > 0) begin
            vectors++;
            if (q_rdy_cyc[0] - c < 2) begin
                miscompares++;
                $display("FAIL wr_first_sample: %0d cycles after command, want >=2", q_rdy_cyc[0] - c);
            end
        end
        for (int i = 1; i < q_rdy_cyc.size(); i++) begin
            vectors++;
            if (q_rdy_cyc[i] - q_rdy_cyc[i-1] != 2) begin
                miscompares++;
                $display("FAIL wr_spacing[%0d]: %0d cycles, want 2", i, q_rdy_cyc[i] - q_rdy_cyc[i-1]);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] a;
        clear_q();
        mem_lat = $urandom_range(1, 3);
        a = $urandom;
        send(1'b0, 1'b1, a, 1'b0, 8'd32);
        wait_idle("single_off", 50);
        vectors++;
        if (q_req_a.size() != 1 || q_rdy_cyc.size() != 1 || q_req_a[0] !== a) begin
            miscompares++;
            $display("FAIL single_burst_off: reqs=%0d rdy=%0d want 1/1 at %h", q_req_a.size(),
                     q_rdy_cyc.size(), a);
        end
        clear_q();
        load_wdata(1);
        send(1'b1, 1'b0, a, 1'b1, 8'd0);
        wait_idle("single_len0", 50);
        vectors++;
        if (q_req_a.size() != 1 || q_rdy_cyc.size() != 1 || q_req_d[0] !== wdata[0]) begin
            miscompares++;
            $display("FAIL single_len0: reqs=%0d rdy=%0d want 1/1 data %h", q_req_a.size(),
                     q_rdy_cyc.size(), wdata[0]);
        end
        clear_q();
        send(1'b0, 1'b1, a, 1'b1, 8'd200);
        wait_idle("clamp", 400);
        vectors++;
        if (q_req_a.size() != 32 || q_rdy_cyc.size() != 32) begin
            miscompares++;
            $display("FAIL clamp_len200: reqs=%0d rdy=%0d want 32/32", q_req_a.size(), q_rdy_cyc.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[4];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
        clear_q();
        mem_lat = $urandom_range(1, 3);
        send(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 8'd4);
        wait_idle("wrap", 100);
        vectors++;
        if (q_req_a.size() != 4) begin
            miscompares++;
            $display("FAIL wrap_count: reqs=%0d want 4", q_req_a.size());
        end
        for (int i = 0; i < q_req_a.size() && i < 4; i++) begin
            vectors++;
            if (q_req_a[i] !== exp_a[i]) begin
                miscompares++;
                $display("FAIL wrap_addr[%0d]: a=%h want %h", i, q_req_a[i], exp_a[i]);
            end
        end
    endtask

    task automatic test_overrun();
        logic [31:0] ea;
        clear_q();
        mem_lat = 2;
        load_wdata(9);
        send(1'b1, 1'b0, 32'h100, 1'b1, 8'd6);
        tick(3);
        send(1'b1, 1'b1, 32'h200, 1'b1, 8'd3);
        tick(2);
        send(1'b0, 1'b1, 32'h300, 1'b1, 8'd2);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: overrun=%b want 1", overrun);
        end
        wait_idle("overrun", 200);
        vectors++;
        if (q_req_a.size() != 9 || q_rdy_cyc.size() != 9 || overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_count: reqs=%0d rdy=%0d ovr=%b want 9/9/1", q_req_a.size(),
                     q_rdy_cyc.size(), overrun);
        end
        for (int i = 0; i < q_req_a.size() && i < 9; i++) begin
            ea = (i < 6) ? 32'h100 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 6));
            vectors++;
            if ({q_req_we[i], q_req_a[i], q_req_d[i]} !== {1'b1, ea, wdata[i]}) begin
                miscompares++;
                $display("FAIL overrun_word[%0d]: we=%b a=%h d=%h want 1 %h %h", i, q_req_we[i],
                         q_req_a[i], q_req_d[i], ea, wdata[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            bit          we;
            bit          en;
            logic [7:0]  len;
            logic [31:0] a;
            int          n;
            clear_q();
            mem_lat = $urandom_range(1, 3);
            we  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 4) != 0);
            len = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
            a   = $urandom;
            n   = exp_words(en, len);
            if (we) load_wdata(n);
            send(we, !we, a, en, len);
            wait_idle("random", n * 8 + 20);
            vectors++;
            if (q_req_a.size() != n || q_rdy_cyc.size() != n) begin
                miscompares++;
                $display("FAIL rand%0d_count: reqs=%0d rdy=%0d want %0d (en=%b len=%0d)", t,
                         q_req_a.size(), q_rdy_cyc.size(), n, en, len);
            end
            for (int i = 0; i < q_req_a.size() && i < n; i++) begin
                vectors++;
                if ({q_req_we[i], q_req_a[i]} !== {we, a + 32'(4 * i)} ||
                    (we && q_req_d[i] !== wdata[i])) begin
                    miscompares++;
                    $display("FAIL rand%0d_word[%0d]: we=%b a=%h d=%h want %b %h", t, i,
                             q_req_we[i], q_req_a[i], q_req_d[i], we, a + 32'(4 * i));
                end
            end
            if (!we) begin
                for (int i = 0; i < q_spo.size() && i < q_rsp.size(); i++) begin
                    vectors++;
                    if (q_spo[i] !== q_rsp[i]) begin
                        miscompares++;
                        $display("FAIL rand%0d_rdata[%0d]: spo=%h want %h", t, i, q_spo[i], q_rsp[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int nreq;
        int nrdy;
        clear_q();
        mem_lat = 2;
        send(1'b0, 1'b1, 32'h4000, 1'b1, 8'd32);
        send(1'b0, 1'b1, 32'h5000, 1'b1, 8'd4);
        while (q_rdy_cyc.size() < 9 && n < 200) begin
            tick(1);
            n++;
        end
        vectors++;
        if (q_rdy_cyc.size() < 9) begin
            miscompares++;
            $display("FAIL midrst_wait: %0d pulses after %0d cycles, want 9", q_rdy_cyc.size(), n);
        end
        rst = 1'b0;
        mem_init_done = 1'b0;
        tick(1);
        vectors++;
        if ({lowmem_ready, mem_we, mem_rd, overrun, busy} !== 5'b00001 ||
            {lowmem_spo, mem_a, mem_d} !== 96'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: flags=%b spo=%h a=%h d=%h want 00001 and zeros",
                     {lowmem_ready, mem_we, mem_rd, overrun, busy}, lowmem_spo, mem_a, mem_d);
        end
        rst = 1'b1;
        nreq = q_req_a.size();
        nrdy = q_rdy_cyc.size();
        tick(10);
        vectors++;
        if (q_rdy_cyc.size() != nrdy || q_req_a.size() != nreq || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_quiet: rdy=%0d reqs=%0d busy=%b want %0d/%0d/1",
                     q_rdy_cyc.size(), q_req_a.size(), busy, nrdy, nreq);
        end
        mem_init_done = 1'b1;
        tick(5);
        vectors++;
        if (busy !== 1'b0 || q_req_a.size() != nreq) begin
            miscompares++;
            $display("FAIL midrst_pending_dropped: busy=%b reqs=%0d want 0/%0d", busy, q_req_a.size(), nreq);
        end
    endtask

    initial begin
        test_reset();
        test_init_hold();
        test_write_burst();
        test_single();
        test_wrap();
        test_overrun();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
